// File: rtl/mux16_1_8b_behav_pkg.sv
// Shared widths and the byte type for the 16:1 byte selector.
package mux_pkg;
  localparam int DW   = 8;
  localparam int NIN  = 16;
  localparam int SELW = 4;

  typedef logic [DW-1:0] byte_t;
endpackage

// File: rtl/mux16_1_8b_behav_if.sv
// Bundle of the selector's data inputs, select and outputs for benches and wrappers.
interface mux16_1_8b_behav_if;
  import mux_pkg::*;

  byte_t             x [NIN];
  logic [SELW-1:0]   sel;
  byte_t             y;
  byte_t             y_q;

  modport master (output x, sel, input  y, y_q);
  modport slave  (input  x, sel, output y, y_q);
endinterface

// File: rtl/mux16_1_8b_behav_mux2.sv
// 2:1 byte selector; an unknown select propagates as all-X rather than picking a side.
module mux2_1_8b
  import mux_pkg::*;
(
  input  byte_t a,
  input  byte_t b,
  input  logic  s,
  output byte_t y
);
  always_comb begin
    case (s)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end
endmodule

// File: rtl/mux16_1_8b_behav.sv
// 16:1 byte mux built as a 4-level tree of 2:1 stages, plus a resettable registered copy.
module mux16_1_8b_behav
  import mux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  byte_t X_0,
  input  byte_t X_1,
  input  byte_t X_2,
  input  byte_t X_3,
  input  byte_t X_4,
  input  byte_t X_5,
  input  byte_t X_6,
  input  byte_t X_7,
  input  byte_t X_8,
  input  byte_t X_9,
  input  byte_t X_10,
  input  byte_t X_11,
  input  byte_t X_12,
  input  byte_t X_13,
  input  byte_t X_14,
  input  byte_t X_15,
  input  logic  sel3,
  input  logic  sel2,
  input  logic  sel1,
  input  logic  sel0,
  output byte_t Y,
  output byte_t Y_q
);
  localparam int NODES = 2*NIN - 1;

  // Heap-style node array: leaves at [0..15], each level packed after the previous,
  // so level l starts at 2*NIN - (2*NIN >> l) and the root lands at NODES-1.
  byte_t [NODES-1:0] node;
  logic  [SELW-1:0]  sel;

  assign sel = {sel3, sel2, sel1, sel0};

  assign node[NIN-1:0] = {X_15, X_14, X_13, X_12, X_11, X_10, X_9, X_8,
                          X_7,  X_6,  X_5,  X_4,  X_3,  X_2,  X_1, X_0};

  for (genvar lvl = 0; lvl < SELW; lvl++) begin : g_lvl
    localparam int IN_BASE  = 2*NIN - ((2*NIN) >> lvl);
    localparam int OUT_BASE = 2*NIN - ((2*NIN) >> (lvl + 1));
    for (genvar i = 0; i < (NIN >> (lvl + 1)); i++) begin : g_node
      mux2_1_8b u_mux2 (
        .a (node[IN_BASE + 2*i]),
        .b (node[IN_BASE + 2*i + 1]),
        .s (sel[lvl]),
        .y (node[OUT_BASE + i])
      );
    end
  end

  assign Y = node[NODES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) Y_q <= '0;
    else        Y_q <= Y;
  end
endmodule

// File: tb/tb_mux16_1_8b_behav.sv
// Directed bench for the 16:1 byte mux: combinational select, sweep, reset and register tracking.
module tb_mux16_1_8b_behav;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mux16_1_8b_behav_if bus ();

  always #5 clk = ~clk;

  mux16_1_8b_behav dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X_0   (bus.x[0]),
    .X_1   (bus.x[1]),
    .X_2   (bus.x[2]),
    .X_3   (bus.x[3]),
    .X_4   (bus.x[4]),
    .X_5   (bus.x[5]),
    .X_6   (bus.x[6]),
    .X_7   (bus.x[7]),
    .X_8   (bus.x[8]),
    .X_9   (bus.x[9]),
    .X_10  (bus.x[10]),
    .X_11  (bus.x[11]),
    .X_12  (bus.x[12]),
    .X_13  (bus.x[13]),
    .X_14  (bus.x[14]),
    .X_15  (bus.x[15]),
    .sel3  (bus.sel[3]),
    .sel2  (bus.sel[2]),
    .sel1  (bus.sel[1]),
    .sel0  (bus.sel[0]),
    .Y     (bus.y),
    .Y_q   (bus.y_q)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    byte_t xv [NIN];
    xv = '{8'h00, 8'h01, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h02, 8'h03,
           8'h61, 8'h62, 8'h63, 8'h90, 8'h91, 8'h92, 8'h93, 8'hF0};
    rst_n = 1'b0;
    for (int i = 0; i < NIN; i++) bus.x[i] = xv[i];

    bus.sel = 4'b1111; #1;
    chk("comb_sel15", bus.y, 8'hF0);
    bus.sel = 4'b1101; #1;
    chk("comb_sel13", bus.y, 8'h92);

    for (int s = 0; s < NIN; s++) begin
      bus.sel = 4'(s); #1;
      chk($sformatf("sweep_sel%0d", s), bus.y, xv[s]);
    end

    // Hold reset across two edges with sel=2
    bus.sel = 4'b0010;
    rst_n   = 1'b0;
    edge_wait();
    edge_wait();
    chk("rst_yq", bus.y_q, 8'h00);
    chk("rst_y",  bus.y,   8'hFF);
    rst_n = 1'b1;
    edge_wait();
    chk("rel_yq", bus.y_q, 8'hFF);

    bus.sel = 4'b0000; edge_wait(); chk("trk_sel0",  bus.y_q, 8'h00);
    bus.sel = 4'b0111; edge_wait(); chk("trk_sel7",  bus.y_q, 8'h03);
    bus.sel = 4'b1000; edge_wait(); chk("trk_sel8",  bus.y_q, 8'h61);
    bus.sel = 4'b1111; edge_wait(); chk("trk_sel15", bus.y_q, 8'hF0);

    bus.x[15] = 8'h5A; #1;
    chk("x15_y_now",   bus.y,   8'h5A);
    chk("x15_yq_hold", bus.y_q, 8'hF0);
    edge_wait();
    chk("x15_yq_next", bus.y_q, 8'h5A);

    // Mid-stream reset pulse, then reload
    rst_n = 1'b0;
    edge_wait();
    chk("mid_rst_yq", bus.y_q, 8'h00);
    chk("mid_rst_y",  bus.y,   8'h5A);
    rst_n = 1'b1;
    edge_wait();
    chk("mid_rel_yq", bus.y_q, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
